// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - per-bit switch debouncer with a shared sample-tick prescaler
// A level is accepted only after STABLE_CNT consecutive ticks of disagreement with sw_out.
module sw_debounce #(
  parameter int WIDTH      = 16,
  parameter int TICK_DIV   = 50000,
  parameter int STABLE_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] changed,
  output logic             tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_CNT - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [PW-1:0]    presc;
  logic [PW-1:0]    presc_next;
  logic [WIDTH-1:0] cnt_last;
  logic [WIDTH-1:0] load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
    end
  end

  always_comb begin
    presc_next = (presc == PRESC_LAST) ? '0 : presc + 1'b1;
  end

  // tick is registered from presc_next so it is high exactly while presc == TICK_DIV-1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      presc <= presc_next;
      tick  <= (presc_next == PRESC_LAST);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CW-1:0] cnt;

    assign cnt_last[i] = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt <= '0;
      end else if ((sync2[i] == sw_out[i]) || load[i]) begin
        cnt <= '0;
      end else if (tick) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign load = (sync2 ^ sw_out) & cnt_last & {WIDTH{tick}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_out  <= '0;
      changed <= '0;
    end else begin
      sw_out  <= sw_out ^ load;
      changed <= load;
    end
  end

endmodule
